tlul_socket_m1_arb: RTL and testbench

M:1 TL-UL socket that merges M host ports onto one device port and steers responses back by source ID. It adds a selectable arbitration policy (round-robin or fixed priority), a per-host outstanding-transaction limit with back-pressure, an optional registered request stage, and sticky detection of misrouted responses. It sits at the device-facing edge of a crossbar, directly in front of a single peripheral or a downstream 1:N socket.

---
 rtl/tlul_pkg.sv | 43 ++++
 rtl/tlul_sock_arb.sv | 49 ++++
 rtl/tlul_socket_m1_arb.sv | 99 +++++++++
 tb/tb_tlul_socket_m1_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types plus constants shared by the M:1 socket.
package tlul_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int SockMaxOutW = 4;
  localparam logic SockArbRr = 1'b1;
  localparam logic SockArbFixed = 1'b0;
  typedef enum logic [2:0] {
    PutFullData = 3'h0,
    PutPartialData = 3'h1,
    Get = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic a_valid;
    tl_a_op_e a_opcode;
    logic [2:0] a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0] a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0] a_data;
    logic d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic d_valid;
    tl_d_op_e d_opcode;
    logic [2:0] d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0] d_data;
    logic d_error;
    logic a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_sock_arb.sv
// tlul_sock_arb: M-way fixed/round-robin arbiter that holds its grant until accepted.
module tlul_sock_arb import tlul_pkg::*; #(
  parameter int M = 4,
  parameter logic ArbRr = SockArbRr
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [M-1:0]         req_i,
  input  logic                 accept_i,
  output logic [M-1:0]         gnt_o,
  output logic [$clog2(M)-1:0] idx_o,
  output logic                 valid_o
);
  localparam int STIDW = $clog2(M);
  logic [STIDW-1:0] ptr, lock_idx, pick, start;
  logic lock, found;
  int j;
  assign start = ArbRr ? ptr : '0;
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = 0;
    for (int k = 0; k < M; k++) begin
      j = (int'(start) + k) % M;
      if (!found && req_i[j]) begin
        found = 1'b1;
        pick = STIDW'(j);
      end
    end
  end
  // A presented-but-stalled request keeps its grant so A-channel content stays stable
  assign idx_o = lock ? lock_idx : pick;
  assign valid_o = lock ? req_i[lock_idx] : found;
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < M; i++) gnt_o[i] = valid_o & (idx_o == STIDW'(i));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
    end else begin
      lock <= valid_o & !accept_i;
      lock_idx <= idx_o;
      if (accept_i) ptr <= STIDW'((int'(idx_o) + 1) % M);
    end
  end
endmodule

// File: rtl/tlul_socket_m1_arb.sv
// tlul_socket_m1_arb: M:1 TL-UL socket with arbitration, per-host outstanding limits
// and source-ID based response steering.
module tlul_socket_m1_arb import tlul_pkg::*; #(
  parameter int M = 4,
  parameter logic ArbRr = SockArbRr,
  parameter int MaxOut = 4,
  parameter logic ReqReg = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  tl_h2d_t                   tl_h_i [M],
  output tl_d2h_t                   tl_h_o [M],
  output tl_h2d_t                   tl_d_o,
  input  tl_d2h_t                   tl_d_i,
  output logic [M*SockMaxOutW-1:0]  outstanding_o,
  output logic                      rsp_err_o
);
  localparam int STIDW = $clog2(M);
  localparam int IDW = TL_AIW;
  localparam logic [SockMaxOutW-1:0] MaxCnt = SockMaxOutW'(MaxOut);
  logic [M-1:0] req, gnt, inc, dec;
  logic [STIDW-1:0] win, rsp_idx;
  logic arb_valid, stage_rdy, accept, rsp_dready, rsp_miss;
  logic [SockMaxOutW-1:0] cnt [M];
  tl_h2d_t req_d, dev_req;
  always_comb begin
    req = '0;
    for (int i = 0; i < M; i++) req[i] = tl_h_i[i].a_valid & (cnt[i] < MaxCnt);
  end
  tlul_sock_arb #(.M(M), .ArbRr(ArbRr)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req),
    .accept_i (accept),
    .gnt_o    (gnt),
    .idx_o    (win),
    .valid_o  (arb_valid)
  );
  assign accept = arb_valid & stage_rdy & !rst_i;
  // Host index goes into the low source bits so responses can be routed back
  always_comb begin
    req_d = '0;
    for (int i = 0; i < M; i++) if (win == STIDW'(i)) req_d = tl_h_i[i];
    req_d.a_valid = arb_valid & !rst_i;
    req_d.a_source = {req_d.a_source[IDW-STIDW-1:0], win};
  end
  if (ReqReg) begin : g_reg
    tl_h2d_t reg_q;
    assign stage_rdy = !reg_q.a_valid | tl_d_i.a_ready;
    always_ff @(posedge clk_i) begin
      if (rst_i) reg_q <= '0;
      else if (stage_rdy) reg_q <= accept ? req_d : '0;
    end
    assign dev_req = reg_q;
  end else begin : g_comb
    assign stage_rdy = tl_d_i.a_ready;
    assign dev_req = req_d;
  end
  always_comb begin
    tl_d_o = dev_req;
    tl_d_o.d_ready = rsp_dready;
  end
  assign rsp_idx = tl_d_i.d_source[STIDW-1:0];
  // Responses to a nonexistent host are swallowed with d_ready held high
  always_comb begin
    inc = '0;
    dec = '0;
    rsp_dready = 1'b1;
    rsp_miss = 1'b1;
    for (int i = 0; i < M; i++) begin
      tl_h_o[i] = tl_d_i;
      tl_h_o[i].d_source = tl_d_i.d_source >> STIDW;
      tl_h_o[i].d_valid = tl_d_i.d_valid & (rsp_idx == STIDW'(i)) & !rst_i;
      tl_h_o[i].a_ready = gnt[i] & stage_rdy & !rst_i;
      inc[i] = tl_h_i[i].a_valid & tl_h_o[i].a_ready;
      dec[i] = tl_h_o[i].d_valid & tl_h_i[i].d_ready;
      if (rsp_idx == STIDW'(i)) begin
        rsp_dready = tl_h_i[i].d_ready;
        rsp_miss = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < M; i++) cnt[i] <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end
      if (tl_d_i.d_valid && rsp_miss) rsp_err_o <= 1'b1;
    end
  end
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < M; i++) outstanding_o[i*SockMaxOutW +: SockMaxOutW] = cnt[i];
  end
endmodule

// File: tb/tb_tlul_socket_m1_arb.sv
// tb_tlul_socket_m1_arb: directed checks of three socket configurations.
module tb_tlul_socket_m1_arb;
  import tlul_pkg::*;
  logic clk, rst, rst_c;
  tl_h2d_t ha [4], hb [3], hc [4];
  tl_d2h_t hoa [4], hob [3], hoc [4];
  tl_h2d_t da, db, dc;
  tl_d2h_t dia, dib, dic;
  logic [15:0] oa, oc;
  logic [11:0] ob;
  logic ea, eb, ec;
  int checks = 0;
  int errors = 0;
  tlul_socket_m1_arb #(.M(4), .ArbRr(1'b1), .MaxOut(2), .ReqReg(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .tl_h_i(ha), .tl_h_o(hoa), .tl_d_o(da), .tl_d_i(dia),
    .outstanding_o(oa), .rsp_err_o(ea));
  tlul_socket_m1_arb #(.M(3), .ArbRr(1'b0), .MaxOut(4), .ReqReg(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .tl_h_i(hb), .tl_h_o(hob), .tl_d_o(db), .tl_d_i(dib),
    .outstanding_o(ob), .rsp_err_o(eb));
  tlul_socket_m1_arb #(.M(4), .ArbRr(1'b1), .MaxOut(15), .ReqReg(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst_c), .tl_h_i(hc), .tl_h_o(hoc), .tl_d_o(dc), .tl_d_i(dic),
    .outstanding_o(oc), .rsp_err_o(ec));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic [7:0] rr_src [5];
  initial begin
    rr_src = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h04};
    rst = 1'b1;
    rst_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ha[i] = '0;
      hc[i] = '0;
      ha[i].a_valid = 1'b1;
      ha[i].a_source = 8'hC1;
    end
    for (int i = 0; i < 3; i++) hb[i] = '0;
    dia = '0;
    dib = '0;
    dic = '0;
    dia.a_ready = 1'b1;
    dic.a_ready = 1'b1;
    repeat (2) tick;
    chk("rst_a_ready", hoa[0].a_ready, 0);
    chk("rst_a_valid", da.a_valid, 0);
    chk("rst_out", oa, 0);
    chk("rst_err", ea, 0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_src", da.a_source, rr_src[k]);
      chk("rr_rdy", hoa[k % 4].a_ready, 1);
      tick;
    end
    for (int i = 0; i < 4; i++) ha[i].a_valid = 1'b0;
    chk("rr_cnt", oa, 16'h1112);
    ha[0].a_valid = 1'b1;
    #1;
    chk("full_rdy", hoa[0].a_ready, 0);
    chk("full_avalid", da.a_valid, 0);
    ha[0].a_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_out", oa, 0);
    ha[1].a_valid = 1'b1;
    ha[1].a_source = 8'h05;
    for (int k = 0; k < 2; k++) begin
      ha[1].a_data = 32'(k);
      #1;
      chk("lim_rdy", hoa[1].a_ready, 1);
      tick;
    end
    chk("lim_cnt", oa[7:4], 2);
    chk("lim_block", hoa[1].a_ready, 0);
    dia.d_valid = 1'b1;
    dia.d_source = 8'h2D;
    dia.d_data = 32'hCAFE0001;
    ha[1].d_ready = 1'b0;
    #1;
    chk("stl_v1", hoa[1].d_valid, 1);
    chk("stl_src", hoa[1].d_source, 8'h0B);
    chk("stl_data", hoa[1].d_data, 32'hCAFE0001);
    chk("stl_v0", hoa[0].d_valid, 0);
    chk("stl_v2", hoa[2].d_valid, 0);
    chk("stl_v3", hoa[3].d_valid, 0);
    chk("stl_dr0", da.d_ready, 0);
    ha[1].d_ready = 1'b1;
    #1;
    chk("stl_dr1", da.d_ready, 1);
    chk("same_cyc_block", hoa[1].a_ready, 0);
    tick;
    dia.d_valid = 1'b0;
    #1;
    chk("lim_cnt_dec", oa[7:4], 1);
    chk("lim_resume", hoa[1].a_ready, 1);
    tick;
    ha[1].a_valid = 1'b0;
    chk("lim_cnt_re", oa[7:4], 2);
    hb[2].a_valid = 1'b1;
    hb[2].a_source = 8'h03;
    hb[2].a_address = 32'h1000_0008;
    #1;
    chk("lk_src0", db.a_source, 8'h0E);
    chk("lk_addr0", db.a_address, 32'h1000_0008);
    chk("lk_rdy0", hob[2].a_ready, 0);
    tick;
    hb[0].a_valid = 1'b1;
    hb[0].a_source = 8'h21;
    hb[0].a_address = 32'h0000_0100;
    #1;
    chk("lk_addr1", db.a_address, 32'h1000_0008);
    chk("lk_src1", db.a_source, 8'h0E);
    chk("lk_rdy_h0", hob[0].a_ready, 0);
    tick;
    chk("lk_addr2", db.a_address, 32'h1000_0008);
    dib.a_ready = 1'b1;
    #1;
    chk("lk_addr3", db.a_address, 32'h1000_0008);
    chk("lk_acc", hob[2].a_ready, 1);
    tick;
    chk("fp_src", db.a_source, 8'h84);
    chk("fp_rdy0", hob[0].a_ready, 1);
    chk("fp_rdy2", hob[2].a_ready, 0);
    tick;
    hb[0].a_valid = 1'b0;
    hb[2].a_valid = 1'b0;
    dib.a_ready = 1'b0;
    chk("fp_cnt", ob, 12'h101);
    chk("mr_err0", eb, 0);
    dib.d_valid = 1'b1;
    dib.d_source = 8'h03;
    #1;
    chk("mr_dr", db.d_ready, 1);
    for (int i = 0; i < 3; i++) chk("mr_dvalid", hob[i].d_valid, 0);
    tick;
    dib.d_valid = 1'b0;
    chk("mr_err1", eb, 1);
    repeat (2) tick;
    chk("mr_sticky", eb, 1);
    chk("mr_cnt", ob, 12'h101);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mr_clr", eb, 0);
    rst_c = 1'b0;
    hc[0].a_valid = 1'b1;
    hc[0].a_source = 8'h02;
    for (int k = 0; k < 8; k++) begin
      hc[0].a_data = 32'(100 + k);
      #1;
      chk("st_rdy", hoc[0].a_ready, 1);
      if (k == 0) chk("st_lat", dc.a_valid, 0);
      else chk("st_data", dc.a_data, 32'(99 + k));
      tick;
    end
    hc[0].a_valid = 1'b0;
    #1;
    chk("st_last", dc.a_data, 32'd107);
    chk("st_lastv", dc.a_valid, 1);
    chk("st_src", dc.a_source, 8'h08);
    chk("st_cnt", oc, 16'h0008);
    tick;
    chk("st_drain", dc.a_valid, 0);
    hc[0].a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hc[0].a_data = 32'(200 + k);
      tick;
    end
    chk("pre_rst_v", dc.a_valid, 1);
    chk("pre_rst_cnt", oc, 16'h000B);
    rst_c = 1'b1;
    tick;
    rst_c = 1'b0;
    hc[0].a_valid = 1'b0;
    #1;
    chk("rst_av", dc.a_valid, 0);
    chk("rst_cnt", oc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
